matmul_tile_engine: RTL and testbench
=====================================

Name: matmul_tile_engine

Overview:
- Parametrised successor of the fixed 4x16x16 DSP-lane multiplier. Computes C = A x B for A (ROWS x DEPTH) and B (DEPTH x COLS) by time-multiplexing products over LANES external DSP multipliers.
- Adds signed/unsigned mode, configurable DSP pipeline latency with tag-aligned accumulation, wider accumulators, and a busy/done pulse handshake.
- Sits between the NPU operand buffers and the DSP slice array.

Parameters:
ROWS, 4, rows of A and C
COLS, 4, columns of B and C
DEPTH, 16, inner dimension (k range)
DATA_W, 8, operand width (max 18)
ACC_W, 24, accumulator/result width (<= 37)
LANES, 5, DSP multipliers available
DSP_LAT, 1, cycles from dsp_a/dsp_b register to valid dsp_out (1..4)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
start  in  1  begin operation; sampled only when idle
signed_mode  in  1  1 = two's-complement operands; sampled at start
a  in  [DATA_W] [0:ROWS-1][0:DEPTH-1]  matrix A; held stable while busy
b  in  [DATA_W] [0:DEPTH-1][0:COLS-1]  matrix B; held stable while busy
c  out  [ACC_W] [0:ROWS-1][0:COLS-1]  result matrix
dsp_a  out  [18] [0:LANES-1]  DSP A operands
dsp_b  out  [18] [0:LANES-1]  DSP B operands
dsp_out  in  [37] [0:LANES-1]  DSP products
dsp_ce  out  1  DSP clock enable
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset, asynchronous: all c, dsp_a, dsp_b = 0; dsp_ce = 0; busy = 0; done = 0; state = IDLE.
- Output indexing: flat index p = r*COLS + col. PASSES = ceil(ROWS*COLS/LANES). In pass q, lane l serves p = q*LANES + l; lanes with p >= ROWS*COLS drive 0 operands and are tagged invalid.
- State machine:
  - IDLE: start=1 at edge E0 → ISSUE. On the same edge: clear all c, latch signed_mode, set busy = 1 and dsp_ce = 1, q = k = 0.
  - ISSUE: one (q, k) pair per cycle at edges E1..E(PASSES*DEPTH). Each lane registers a[r][k] and b[k][col], zero- or sign-extended to 18 bits per the latched mode. k wraps DEPTH-1 → 0 and increments q. After the last pair → DRAIN.
  - DRAIN: DSP_LAT cycles. Operands are driven to 0 and tagged invalid; then → IDLE.
- Tag alignment: a DSP_LAT-deep shift register carries {valid, p} per lane. When a tag exits valid, c[p] += dsp_out[l] sign- or zero-extended to ACC_W; in signed mode use dsp_out[ACC_W-1:0] with sign bit 36. Plain wrap modulo 2^ACC_W unless saturation is compiled in.
- Completion: the last accumulate happens at edge E(PASSES*DEPTH + DSP_LAT). On that same edge done = 1 for exactly one cycle, busy = 0, dsp_ce = 0. Defaults: E65.
- c holds its value after done until the next accepted start.
- start while busy: ignored. start on the done cycle: accepted (state is IDLE).
- signed_mode changes mid-operation: no effect.
- Reset mid-operation: abort immediately to reset values; no done pulse.
- a/b changes while busy: undefined results. Not checked.

Optional Feature:
- Macro: MATMUL_SAT_EN.
- Defined: each accumulate saturates to the ACC_W range. Signed mode: [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Unsigned mode: [0, 2^ACC_W-1]. A saturated element stays clamped until the next start. An extra output port sat_flag (1 bit) is set if any element clamped in the operation; it clears on start and resets to 0.
- Not defined: modulo wrap, no sat_flag port.

Test Plan:
1. Defaults, DSP model latency 1. A = all 1, B = all 2, unsigned, start → done exactly 65 cycles after start edge; every c = 32; busy high during cycles 1..65.
2. Signed: a[r][k] = -3 (8'hFD), b = 5 everywhere → every c = -240 (24'hFFFF10). Same data unsigned → every c = 253*5*16 = 20240.
3. Identity: B = identity (DEPTH=COLS=4 config, LANES=3, PASSES=6), A = random → C = A's first 4 columns. Lanes beyond p = 15 keep operands 0.
4. DSP_LAT=3, defaults otherwise, A = B = all 255 unsigned → every c = 1,040,400; done at edge E67; no lost or duplicated accumulates (scoreboard per p).
5. start pulsed again at cycle 10 of a run → ignored, single done. Reset at cycle 30 → all outputs 0, no done; a new start → correct result.
6. MATMUL_SAT_EN, ACC_W=16, signed, A = B = all 127 → every c = 32767, sat_flag = 1. A = 127, B = -128 → c = -32768. Without macro → c = 258064 mod 65536 = 61456.

Source files
------------

// File: rtl/matmul_tile_engine.sv
// Tile matrix multiplier: C = A x B with products time-multiplexed over LANES external DSPs.
// Compile with MATMUL_SAT_EN for saturating accumulation and a sat_flag output.
module matmul_tile_engine #(
    parameter int unsigned ROWS    = 4,
    parameter int unsigned COLS    = 4,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ACC_W   = 24,
    parameter int unsigned LANES   = 5,
    parameter int unsigned DSP_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              signed_mode,
    input  logic [DATA_W-1:0] a       [0:ROWS-1][0:DEPTH-1],
    input  logic [DATA_W-1:0] b       [0:DEPTH-1][0:COLS-1],
    output logic [ACC_W-1:0]  c       [0:ROWS-1][0:COLS-1],
    output logic [17:0]       dsp_a   [0:LANES-1],
    output logic [17:0]       dsp_b   [0:LANES-1],
    input  logic [36:0]       dsp_out [0:LANES-1],
    output logic              dsp_ce,
    output logic              busy,
    output logic              done
`ifdef MATMUL_SAT_EN
    ,
    output logic              sat_flag
`endif
);

    localparam int unsigned NumP   = ROWS * COLS;
    localparam int unsigned Passes = (NumP + LANES - 1) / LANES;
    localparam int unsigned PW     = $clog2(Passes * LANES + 1);
    localparam int unsigned QW     = (Passes > 1) ? $clog2(Passes) : 1;
    localparam int unsigned KW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW     = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned DW     = (DSP_LAT > 1) ? $clog2(DSP_LAT) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e         state_q, state_d;
    logic [QW-1:0]  q_q, q_d;
    logic [KW-1:0]  k_q, k_d;
    logic [DW-1:0]  drain_q, drain_d;
    logic           mode_q, mode_d;
    logic           busy_q, busy_d;
    logic           ce_q, ce_d;
    logic           done_q, done_d;
    logic           issue;
    logic           unused_dsp;

    logic [17:0]    dsp_a_q [0:LANES-1];
    logic [17:0]    dsp_a_d [0:LANES-1];
    logic [17:0]    dsp_b_q [0:LANES-1];
    logic [17:0]    dsp_b_d [0:LANES-1];
    logic [PW-1:0]  lane_p  [0:LANES-1];
    logic [RW-1:0]  lane_r  [0:LANES-1];
    logic [CW-1:0]  lane_c  [0:LANES-1];

    // Tag pipeline: stage DSP_LAT-1 lines up with the product on dsp_out.
    logic           tag_v_q  [0:DSP_LAT-1][0:LANES-1];
    logic [PW-1:0]  tag_p_q  [0:DSP_LAT-1][0:LANES-1];
    logic           tag_v_in [0:LANES-1];
    logic [PW-1:0]  tag_p_in [0:LANES-1];

    logic [ACC_W-1:0] c_q [0:NumP-1];
    logic [ACC_W-1:0] c_d [0:NumP-1];

`ifdef MATMUL_SAT_EN
    localparam int unsigned SW = 40;
    localparam logic signed [SW-1:0] SatSMax = SW'((64'd1 << (ACC_W - 1)) - 64'd1);
    localparam logic signed [SW-1:0] SatSMin = ~SatSMax;
    localparam logic signed [SW-1:0] SatUMax = SW'((64'd1 << ACC_W) - 64'd1);

    logic                 sat_elem_q [0:NumP-1];
    logic                 sat_elem_d [0:NumP-1];
    logic                 sat_flag_q, sat_flag_d;
    logic signed [SW-1:0] acc_cur, acc_add, acc_sum, acc_lo, acc_hi;

    assign sat_flag = sat_flag_q;
`endif

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_p[l] = PW'(q_q) * PW'(LANES) + PW'(l);
            lane_r[l] = RW'(lane_p[l] / PW'(COLS));
            lane_c[l] = CW'(lane_p[l] % PW'(COLS));
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        k_d     = k_q;
        drain_d = drain_q;
        mode_d  = mode_q;
        busy_d  = busy_q;
        ce_d    = ce_q;
        done_d  = 1'b0;
        issue   = 1'b0;
        c_d     = c_q;
`ifdef MATMUL_SAT_EN
        sat_elem_d = sat_elem_q;
        sat_flag_d = sat_flag_q;
        acc_cur    = '0;
        acc_add    = '0;
        acc_sum    = '0;
        acc_lo     = '0;
        acc_hi     = '0;
`endif

        for (int pi = 0; pi < NumP; pi++) begin
            for (int l = 0; l < LANES; l++) begin
                if (tag_v_q[DSP_LAT-1][l] && tag_p_q[DSP_LAT-1][l] == PW'(pi)) begin
`ifdef MATMUL_SAT_EN
                    // Once clamped an element ignores further products until the next start.
                    if (!sat_elem_d[pi]) begin
                        if (mode_q) begin
                            acc_cur = SW'($signed(c_d[pi]));
                            acc_add = SW'($signed(dsp_out[l]));
                            acc_lo  = SatSMin;
                            acc_hi  = SatSMax;
                        end else begin
                            acc_cur = SW'(c_d[pi]);
                            acc_add = SW'(dsp_out[l]);
                            acc_lo  = '0;
                            acc_hi  = SatUMax;
                        end
                        acc_sum = acc_cur + acc_add;
                        if (acc_sum > acc_hi) begin
                            acc_sum        = acc_hi;
                            sat_elem_d[pi] = 1'b1;
                            sat_flag_d     = 1'b1;
                        end else if (acc_sum < acc_lo) begin
                            acc_sum        = acc_lo;
                            sat_elem_d[pi] = 1'b1;
                            sat_flag_d     = 1'b1;
                        end
                        c_d[pi] = ACC_W'(acc_sum);
                    end
`else
                    c_d[pi] = c_d[pi] + ACC_W'(dsp_out[l]);
`endif
                end
            end
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StIssue;
                    mode_d  = signed_mode;
                    busy_d  = 1'b1;
                    ce_d    = 1'b1;
                    q_d     = '0;
                    k_d     = '0;
                    for (int pi = 0; pi < NumP; pi++) begin
                        c_d[pi] = '0;
`ifdef MATMUL_SAT_EN
                        sat_elem_d[pi] = 1'b0;
`endif
                    end
`ifdef MATMUL_SAT_EN
                    sat_flag_d = 1'b0;
`endif
                end
            end
            StIssue: begin
                issue = 1'b1;
                if (k_q == KW'(DEPTH - 1)) begin
                    k_d = '0;
                    if (q_q == QW'(Passes - 1)) begin
                        state_d = StDrain;
                        drain_d = '0;
                    end else begin
                        q_d = q_q + 1'b1;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StDrain: begin
                if (drain_q == DW'(DSP_LAT - 1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    ce_d    = 1'b0;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        for (int l = 0; l < LANES; l++) begin
            tag_v_in[l] = issue && (lane_p[l] < PW'(NumP));
            tag_p_in[l] = lane_p[l];
            dsp_a_d[l]  = '0;
            dsp_b_d[l]  = '0;
            if (tag_v_in[l]) begin
                if (mode_q) begin
                    dsp_a_d[l] = 18'($signed(a[lane_r[l]][k_q]));
                    dsp_b_d[l] = 18'($signed(b[k_q][lane_c[l]]));
                end else begin
                    dsp_a_d[l] = 18'(a[lane_r[l]][k_q]);
                    dsp_b_d[l] = 18'(b[k_q][lane_c[l]]);
                end
            end
        end
    end

    // Upper product bits only matter when saturation is compiled in.
    always_comb begin
        unused_dsp = 1'b0;
        for (int l = 0; l < LANES; l++) unused_dsp = unused_dsp ^ (^dsp_out[l]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            q_q     <= '0;
            k_q     <= '0;
            drain_q <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            ce_q    <= 1'b0;
            done_q  <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                dsp_a_q[l] <= '0;
                dsp_b_q[l] <= '0;
                for (int s = 0; s < DSP_LAT; s++) begin
                    tag_v_q[s][l] <= 1'b0;
                    tag_p_q[s][l] <= '0;
                end
            end
            for (int pi = 0; pi < NumP; pi++) begin
                c_q[pi] <= '0;
`ifdef MATMUL_SAT_EN
                sat_elem_q[pi] <= 1'b0;
`endif
            end
`ifdef MATMUL_SAT_EN
            sat_flag_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            k_q     <= k_d;
            drain_q <= drain_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            ce_q    <= ce_d;
            done_q  <= done_d;
            dsp_a_q <= dsp_a_d;
            dsp_b_q <= dsp_b_d;
            for (int l = 0; l < LANES; l++) begin
                tag_v_q[0][l] <= tag_v_in[l];
                tag_p_q[0][l] <= tag_p_in[l];
                for (int s = 1; s < DSP_LAT; s++) begin
                    tag_v_q[s][l] <= tag_v_q[s-1][l];
                    tag_p_q[s][l] <= tag_p_q[s-1][l];
                end
            end
            c_q <= c_d;
`ifdef MATMUL_SAT_EN
            sat_elem_q <= sat_elem_d;
            sat_flag_q <= sat_flag_d;
`endif
        end
    end

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            for (int col = 0; col < COLS; col++) c[r][col] = c_q[r*COLS + col];
        end
    end

    assign dsp_a  = dsp_a_q;
    assign dsp_b  = dsp_b_q;
    assign dsp_ce = ce_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_matmul_tile_engine.sv
// Bench: two engines (ACC_W=16/DSP_LAT=1 and ACC_W=24/DSP_LAT=3) with behavioural DSP models.
// Uniform-matrix vectors from a table, plus identity, restart-ignore and mid-run reset sequences.
module tb_matmul_tile_engine;
    localparam int ROWS = 4, COLS = 4, DEPTH = 16, LANES = 5;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0, signed_mode = 1'b0;
    logic [7:0]  a [0:ROWS-1][0:DEPTH-1];
    logic [7:0]  b [0:DEPTH-1][0:COLS-1];
    logic [15:0] c_a [0:ROWS-1][0:COLS-1];
    logic [23:0] c_b [0:ROWS-1][0:COLS-1];
    logic [17:0] dsp_a_a [0:LANES-1], dsp_b_a [0:LANES-1];
    logic [17:0] dsp_a_b [0:LANES-1], dsp_b_b [0:LANES-1];
    logic [36:0] dsp_out_a [0:LANES-1], dsp_out_b [0:LANES-1];
    logic [36:0] pipe1_b [0:LANES-1], pipe2_b [0:LANES-1];
    logic        ce_a, busy_a, done_a, ce_b, busy_b, done_b;
`ifdef MATMUL_SAT_EN
    logic        sat_a, sat_b;
`endif

    typedef struct {
        int         which;
        logic       sgn;
        logic [7:0] av;
        logic [7:0] bv;
        logic [23:0] exp_c;
        int         exp_done;
        logic       exp_sat;
    } vec_t;

    int          n_pass = 0;
    int          n_total = 0;
    logic [23:0] sb_q [$];
    vec_t        vecs [8];

    always #5 clk = ~clk;

    matmul_tile_engine #(.ACC_W(16), .DSP_LAT(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .signed_mode(signed_mode),
        .a(a), .b(b), .c(c_a), .dsp_a(dsp_a_a), .dsp_b(dsp_b_a), .dsp_out(dsp_out_a),
        .dsp_ce(ce_a), .busy(busy_a), .done(done_a)
`ifdef MATMUL_SAT_EN
        , .sat_flag(sat_a)
`endif
    );

    matmul_tile_engine #(.ACC_W(24), .DSP_LAT(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .signed_mode(signed_mode),
        .a(a), .b(b), .c(c_b), .dsp_a(dsp_a_b), .dsp_b(dsp_b_b), .dsp_out(dsp_out_b),
        .dsp_ce(ce_b), .busy(busy_b), .done(done_b)
`ifdef MATMUL_SAT_EN
        , .sat_flag(sat_b)
`endif
    );

    // Latency 1: product visible in the cycle after the operand register.
    always_comb begin
        for (int l = 0; l < LANES; l++)
            dsp_out_a[l] = 37'($signed(dsp_a_a[l])) * 37'($signed(dsp_b_a[l]));
    end

    // Latency 3: two more register stages behind the operand register.
    always @(posedge clk) begin
        if (ce_b) begin
            for (int l = 0; l < LANES; l++) begin
                pipe1_b[l] <= 37'($signed(dsp_a_b[l])) * 37'($signed(dsp_b_b[l]));
                pipe2_b[l] <= pipe1_b[l];
            end
        end
    end
    assign dsp_out_b = pipe2_b;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic get_busy(input int which);
        return (which == 0) ? busy_a : busy_b;
    endfunction

    function automatic logic get_done(input int which);
        return (which == 0) ? done_a : done_b;
    endfunction

    function automatic logic get_ce(input int which);
        return (which == 0) ? ce_a : ce_b;
    endfunction

    function automatic longint get_c(input int which, input int r, input int col);
        return (which == 0) ? longint'(c_a[r][col]) : longint'(c_b[r][col]);
    endfunction

    function automatic int count_c_nonzero(input int which);
        int n = 0;
        for (int r = 0; r < ROWS; r++)
            for (int col = 0; col < COLS; col++) if (get_c(which, r, col) != 0) n++;
        return n;
    endfunction

    function automatic int count_dsp_nonzero(input int which);
        int n = 0;
        for (int l = 0; l < LANES; l++) begin
            if (which == 0 && (dsp_a_a[l] != 0 || dsp_b_a[l] != 0)) n++;
            if (which == 1 && (dsp_a_b[l] != 0 || dsp_b_b[l] != 0)) n++;
        end
        return n;
    endfunction

    task automatic set_start(input int which, input logic v);
        if (which == 0) start_a = v;
        else start_b = v;
    endtask

    task automatic fill(input logic [7:0] av, input logic [7:0] bv);
        for (int r = 0; r < ROWS; r++) for (int k = 0; k < DEPTH; k++) a[r][k] = av;
        for (int k = 0; k < DEPTH; k++) for (int col = 0; col < COLS; col++) b[k][col] = bv;
    endtask

    task automatic push_uniform(input logic [23:0] v);
        for (int i = 0; i < ROWS * COLS; i++) sb_q.push_back(v);
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int w = 0; w < 2; w++) begin
            check($sformatf("%s_busy%0d", tag, w), get_busy(w), 0);
            check($sformatf("%s_done%0d", tag, w), get_done(w), 0);
            check($sformatf("%s_ce%0d", tag, w), get_ce(w), 0);
            check($sformatf("%s_c_nonzero%0d", tag, w), count_c_nonzero(w), 0);
            check($sformatf("%s_dsp_nonzero%0d", tag, w), count_dsp_nonzero(w), 0);
        end
    endtask

    // Starts one operation, follows it to done, then pops and compares the scoreboard entry.
    task automatic run_op(input int which, input int exp_done, input bit repulse,
                          input bit chk_lanes);
        int  done_at = -1;
        bit  busy_ok = 1'b1;
        bit  lane_ok = 1'b1;
        @(negedge clk);
        set_start(which, 1'b1);
        @(posedge clk);
        #1;
        set_start(which, 1'b0);
        signed_mode = ~signed_mode;
        check($sformatf("busy_after_start%0d", which), get_busy(which), 1);
        check($sformatf("done_low_after_start%0d", which), get_done(which), 0);
        check($sformatf("c_cleared%0d", which), count_c_nonzero(which), 0);
        for (int n = 1; n <= exp_done + 20 && done_at < 0; n++) begin
            if (repulse && n == 10) begin
                @(negedge clk);
                set_start(which, 1'b1);
                @(posedge clk);
                #1;
                set_start(which, 1'b0);
            end else begin
                @(posedge clk);
                #1;
            end
            if (get_done(which)) done_at = n;
            else if (!get_busy(which) || !get_ce(which)) busy_ok = 1'b0;
            if (chk_lanes && n >= 49 && n <= 64) begin
                for (int l = 1; l < LANES; l++)
                    if (dsp_a_a[l] != 0 || dsp_b_a[l] != 0) lane_ok = 1'b0;
            end
        end
        check($sformatf("done_cycle%0d", which), done_at, exp_done);
        check($sformatf("busy_while_running%0d", which), busy_ok, 1);
        if (chk_lanes) check("unused_lanes_zero", lane_ok, 1);
        if (done_at >= 0) begin
            check($sformatf("busy_low_at_done%0d", which), get_busy(which), 0);
            check($sformatf("ce_low_at_done%0d", which), get_ce(which), 0);
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int col = 0; col < COLS; col++) begin
                logic [23:0] e;
                e = (sb_q.size() > 0) ? sb_q.pop_front() : 24'hFFFFFF;
                check($sformatf("c%0d[%0d][%0d]", which, r, col), get_c(which, r, col),
                      longint'(e));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int  seen;
        vecs[0] = '{1, 1'b1, 8'hFD, 8'd5,   24'hFFFF10, 67, 1'b0};
        vecs[1] = '{1, 1'b0, 8'hFD, 8'd5,   24'd20240,  67, 1'b0};
        vecs[2] = '{0, 1'b1, 8'hFD, 8'd5,   24'h00FF10, 65, 1'b0};
        vecs[3] = '{1, 1'b0, 8'hFF, 8'hFF,  24'd1040400, 67, 1'b0};
`ifdef MATMUL_SAT_EN
        vecs[4] = '{0, 1'b1, 8'd127, 8'd127, 24'd32767,  65, 1'b1};
        vecs[5] = '{0, 1'b1, 8'd127, 8'h80,  24'h008000, 65, 1'b1};
`else
        vecs[4] = '{0, 1'b1, 8'd127, 8'd127, 24'd61456,  65, 1'b0};
        vecs[5] = '{0, 1'b1, 8'd127, 8'h80,  24'd2048,   65, 1'b0};
`endif
        vecs[6] = '{1, 1'b1, 8'd127, 8'd127, 24'd258064, 67, 1'b0};
        vecs[7] = '{0, 1'b0, 8'd1,   8'd2,   24'd32,     65, 1'b0};

        fill(8'd0, 8'd0);
        #23;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            fill(vecs[i].av, vecs[i].bv);
            signed_mode = vecs[i].sgn;
            push_uniform(vecs[i].exp_c);
            run_op(vecs[i].which, vecs[i].exp_done, 1'b0, 1'b0);
`ifdef MATMUL_SAT_EN
            check($sformatf("sat_flag_vec%0d", i), (vecs[i].which == 0) ? sat_a : sat_b,
                  vecs[i].exp_sat);
`endif
        end

        // Identity B: C is the first COLS columns of A; pass 3 lanes 1..4 must stay idle.
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < DEPTH; k++) a[r][k] = 8'($urandom_range(0, 255));
        for (int k = 0; k < DEPTH; k++)
            for (int col = 0; col < COLS; col++) b[k][col] = (k == col) ? 8'd1 : 8'd0;
        signed_mode = 1'b0;
        for (int r = 0; r < ROWS; r++)
            for (int col = 0; col < COLS; col++) sb_q.push_back(24'(a[r][col]));
        run_op(0, 65, 1'b0, 1'b1);

        // Second start mid-run is ignored: one done, then result holds.
        fill(8'd1, 8'd2);
        signed_mode = 1'b0;
        push_uniform(24'd32);
        run_op(1, 67, 1'b1, 1'b0);
        seen = 0;
        for (int n = 0; n < 80; n++) begin
            @(posedge clk);
            #1;
            if (done_b || busy_b) seen++;
        end
        check("no_second_op", seen, 0);
        check("c_holds_after_done", get_c(1, 3, 3), 32);

        // Reset at cycle 30 aborts without done; the next start still gives a correct result.
        fill(8'd1, 8'd2);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        check("busy_before_abort", busy_a, 1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int n = 0; n < 80; n++) begin
            @(posedge clk);
            #1;
            if (done_a || busy_a) seen++;
        end
        check("no_done_after_abort", seen, 0);
        fill(8'd3, 8'd4);
        signed_mode = 1'b0;
        push_uniform(24'd192);
        run_op(0, 65, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
